dmem_responder: RTL

- Memory-side responder for the core's memory-stage load/store requests. It is the far end of the data-memory interface.
- Accepts one request at a time through a valid/ready handshake. Services it after a fixed, parameterised latency. Returns one registered response pulse.
- Holds `stall` high so the pipeline freezes the memory stage until the response arrives.
- Implements byte, half and word access selected by funct3: little-endian lanes and load sign/zero extension.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 93 +++++++++
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings and FSM state type shared by the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian lane steering for stores and extraction/extension for loads.
// Optional misaligned-access detection: define DMEM_MISALIGN_TRAP_EN.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Misalignment: only halfword/word accesses can be misaligned; byte never is.
    always_comb begin
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        case (funct3)
            F3_H:    misalign = addr_lo[0];
            F3_HU:   misalign = addr_lo[0] & ~is_store;
            F3_W:    misalign = (addr_lo != 2'b00);
            default: misalign = 1'b0;
        endcase
`endif
    end

    // Store steering: replicate data across lanes, the mask picks the lanes written.
    always_comb begin
        wmask    = 4'b0000;
        wdata_sh = 32'h0000_0000;
        if (is_store && !misalign) begin
            case (funct3)
                F3_B: begin
                    wmask    = 4'b0001 << addr_lo;
                    wdata_sh = {4{wdata[7:0]}};
                end
                F3_H: begin
                    wmask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_sh = {2{wdata[15:0]}};
                end
                F3_W: begin
                    wmask    = 4'b1111;
                    wdata_sh = wdata;
                end
                default: begin
                    wmask    = 4'b0000;
                    wdata_sh = 32'h0000_0000;
                end
            endcase
        end else begin
            wmask    = 4'b0000;
            wdata_sh = 32'h0000_0000;
        end
    end

    // Load extraction: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = raw_word[7:0];
            2'b01:   byte_s = raw_word[15:8];
            2'b10:   byte_s = raw_word[23:16];
            2'b11:   byte_s = raw_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = raw_word[31:16];
        end else begin
            half_s = raw_word[15:0];
        end
        if (misalign) begin
            load_data = 32'h0000_0000;
        end else begin
            case (funct3)
                F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
                F3_H:    load_data = {{16{half_s[15]}}, half_s};
                F3_W:    load_data = raw_word;
                F3_BU:   load_data = {24'h00_0000, byte_s};
                F3_HU:   load_data = {16'h0000, half_s};
                default: load_data = 32'h0000_0000;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding, fixed-latency data-memory responder for the memory stage.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall,
    output logic                  resp_err
);

    localparam int         AW       = DEPTH_LOG2 + 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  write_q, write_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic [31:0]           mem_q [0:(1 << DEPTH_LOG2) - 1];
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic [31:0]           raw_word_s;
    logic [31:0]           wdata_sh_s;
    logic [31:0]           load_data_s;
    logic [3:0]            wmask_s;
    logic                  misalign_s;
    logic                  enter_resp_s;
    logic                  mem_we_s;
    logic                  unused_addr_s;

    // The lane logic sees the request as it will be latched, so LATENCY==1 works from IDLE.
    assign word_idx_s    = addr_d[AW-1:2];
    assign raw_word_s    = mem_q[word_idx_s];
    assign mem_we_s      = enter_resp_s & ~rst;
    assign unused_addr_s = ^req_addr[DATA_WIDTH-1:AW];

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign stall      = req_valid & ~resp_valid_q;

    dmem_lane_align u_lane_align (
        .is_store  (write_d),
        .funct3    (funct3_d),
        .addr_lo   (addr_d[1:0]),
        .wdata     (wdata_d),
        .raw_word  (raw_word_s),
        .wmask     (wmask_s),
        .wdata_sh  (wdata_sh_s),
        .load_data (load_data_s),
        .misalign  (misalign_s)
    );

    // Next state, latency countdown and request latching.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[AW-1:0];
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response outputs are computed for the edge that enters RESP.
    always_comb begin
        enter_resp_s = (state_d == RESP) && (state_q != RESP);
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = enter_resp_s;
        resp_err_d   = enter_resp_s & misalign_s;
        if (enter_resp_s && (!write_d || misalign_s)) begin
            resp_rdata_d = load_data_s;
        end else begin
            resp_rdata_d = resp_rdata_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= 3'b000;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage keeps its contents across reset; stores commit byte-masked on RESP entry.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_q[word_idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
                end
            end
        end
    end

endmodule
